// File: rtl/systolic_mm_if.sv
// Job/result bundle for the systolic matrix-multiply engine.
// The engine takes the slave view; the operand source / result sink takes the master view.
interface systolic_mm_if #(
  parameter int N      = 4,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40
) ();
  localparam int IDX_W = $clog2(N * N);

  logic                  in_valid;
  logic                  in_ready;
  logic                  in_last;
  logic [N*DATA_W-1:0]   a_vec;
  logic [N*DATA_W-1:0]   b_vec;
  logic                  out_valid;
  logic                  out_ready;
  logic [ACC_W-1:0]      out_data;
  logic [IDX_W-1:0]      out_idx;
  logic                  out_last;
  logic                  busy;
  logic                  err_len;

  modport slave (
    input  in_valid, in_last, a_vec, b_vec, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last, busy, err_len
  );

  modport master (
    output in_valid, in_last, a_vec, b_vec, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last, busy, err_len
  );
endinterface

// File: rtl/systolic_mm_engine.sv
// Output-stationary NxN systolic array computing C = A x B over a variable inner dimension K,
// with internal operand skewing, a drain phase and serialised, back-pressured result readout.
module systolic_mm_engine #(
  parameter int N      = 4,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int KMAX   = 256
) (
  input  logic           clk,
  input  logic           rst,
  systolic_mm_if.slave   bus
);

  localparam int IDX_W  = $clog2(N * N);
  localparam int BEAT_W = $clog2(KMAX);
  localparam int DRN_W  = $clog2(2 * N);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_OUT} state_e;
  typedef logic signed [DATA_W-1:0] opnd_t;

  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [DRN_W-1:0]    drain_q, drain_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                err_q, err_d;

  logic                in_fire, out_fire, acc_clr, last_beat, trunc;
  logic [BEAT_W-1:0]   cur_beat;

  opnd_t               a_skew_q [N][N];
  opnd_t               b_skew_q [N][N];
  opnd_t               a_pe_q   [N][N];
  opnd_t               b_pe_q   [N][N];
  opnd_t               a_in     [N][N];
  opnd_t               b_in     [N][N];
  logic signed [ACC_W-1:0] acc_q    [N*N];
  logic signed [ACC_W-1:0] prod_ext [N][N];

  function automatic logic signed [ACC_W-1:0] mul_ext(opnd_t a, opnd_t b);
    logic signed [2*DATA_W-1:0] p;
    p = a * b;
    return ACC_W'(p);
  endfunction

  assign bus.in_ready  = !rst && (state_q == S_IDLE || state_q == S_LOAD);
  assign bus.out_valid = (state_q == S_OUT);
  assign bus.out_data  = (state_q == S_OUT) ? acc_q[idx_q] : '0;
  assign bus.out_idx   = idx_q;
  assign bus.out_last  = (state_q == S_OUT) && (idx_q == IDX_W'(N * N - 1));
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.err_len   = err_q;

  assign in_fire   = bus.in_valid && bus.in_ready;
  assign out_fire  = bus.out_valid && bus.out_ready;
  // The first beat of a job always counts as beat 0, whatever the counter holds.
  assign cur_beat  = (state_q == S_IDLE) ? '0 : beat_q;
  assign trunc     = !bus.in_last && (cur_beat == BEAT_W'(KMAX - 1));
  assign last_beat = bus.in_last || trunc;

  always_comb begin
    // NOTE: every variable gets its default before the case, so no path can infer a latch.
    state_d = state_q;
    beat_d  = beat_q;
    drain_d = drain_q;
    idx_d   = idx_q;
    err_d   = err_q;
    acc_clr = 1'b0;
    unique case (state_q)
      S_IDLE: if (in_fire) begin
        acc_clr = 1'b1;
        err_d   = trunc;
        beat_d  = BEAT_W'(1);
        drain_d = '0;
        state_d = last_beat ? S_DRAIN : S_LOAD;
      end
      S_LOAD: if (in_fire) begin
        beat_d = beat_q + BEAT_W'(1);
        if (last_beat) begin
          err_d   = err_q | trunc;
          drain_d = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        drain_d = drain_q + DRN_W'(1);
        if (drain_q == DRN_W'(2 * N - 1)) begin
          idx_d   = '0;
          state_d = S_OUT;
        end
      end
      S_OUT: if (out_fire) begin
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(N * N - 1)) begin
          idx_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    if (rst) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      drain_q <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      drain_q <= drain_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  // Row i of A enters PE(i,0) from skew tap i; column j of B enters PE(0,j) from skew tap j.
  always_comb begin
    a_in     = '{default: '0};
    b_in     = '{default: '0};
    prod_ext = '{default: '0};
    for (int i = 0; i < N; i++) begin
      a_in[i][0] = a_skew_q[i][i];
      b_in[0][i] = b_skew_q[i][i];
      for (int j = 1; j < N; j++) begin
        a_in[i][j] = a_pe_q[i][j-1];
        b_in[j][i] = b_pe_q[j-1][i];
      end
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        prod_ext[i][j] = mul_ext(a_in[i][j], b_in[i][j]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the datapath arrays are reset explicitly so an aborted job leaves no stale partial sums.
      a_skew_q <= '{default: '0};
      b_skew_q <= '{default: '0};
      a_pe_q   <= '{default: '0};
      b_pe_q   <= '{default: '0};
      acc_q    <= '{default: '0};
    end else begin
      for (int i = 0; i < N; i++) begin
        a_skew_q[i][0] <= in_fire ? opnd_t'(bus.a_vec[i*DATA_W +: DATA_W]) : '0;
        b_skew_q[i][0] <= in_fire ? opnd_t'(bus.b_vec[i*DATA_W +: DATA_W]) : '0;
        for (int d = 1; d < N; d++) begin
          a_skew_q[i][d] <= a_skew_q[i][d-1];
          b_skew_q[i][d] <= b_skew_q[i][d-1];
        end
      end
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_pe_q[i][j]  <= a_in[i][j];
          b_pe_q[i][j]  <= b_in[i][j];
          acc_q[i*N+j]  <= acc_clr ? '0 : acc_q[i*N+j] + prod_ext[i][j];
        end
      end
    end
  end

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Self-checking bench for systolic_mm_engine: job table driven through a result scoreboard,
// plus hand-written sequences for stall, mid-drain reset and KMAX truncation.
module tb_systolic_mm_engine;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 40;
  localparam int P  = 10;

  typedef logic [N*DW-1:0] vec_t;

  typedef struct {
    string  name;
    int     k;
    bit     bubbles;
    bit     stall;
    vec_t   a [4];
    vec_t   b [4];
    int     spot_idx [2];
    longint spot_val [2];
  } job_t;

  typedef struct {
    int                   idx;
    logic signed [AW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #(P/2) clk = ~clk;

  systolic_mm_if #(.N(N), .DATA_W(DW), .ACC_W(AW)) bus  ();
  systolic_mm_if #(.N(N), .DATA_W(DW), .ACC_W(AW)) bus8 ();

  systolic_mm_engine #(.N(N), .DATA_W(DW), .ACC_W(AW), .KMAX(256)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  systolic_mm_engine #(.N(N), .DATA_W(DW), .ACC_W(AW), .KMAX(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb [$];
  bit   job_done;
  bit   first_seen;
  time  t_first;
  time  t_last;
  logic signed [AW-1:0] got [N*N];
  job_t jobs [4];
  job_t rj;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t lanes(input int v0, input int v1, input int v2, input int v3);
    return {DW'(v3), DW'(v2), DW'(v1), DW'(v0)};
  endfunction

  function automatic logic signed [AW-1:0] model(input job_t j, input int r, input int c);
    logic signed [AW-1:0] s;
    s = '0;
    for (int k = 0; k < j.k; k++)
      s = s + ($signed(j.a[k][r*DW +: DW]) * $signed(j.b[k][c*DW +: DW]));
    return s;
  endfunction

  // Scoreboard consumer: every valid cycle is compared against the head entry, popped on transfer.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid) begin
        if (!first_seen) begin
          first_seen = 1'b1;
          t_first    = $time;
        end
        if (sb.size() == 0) begin
          check("unexpected_out", bus.out_valid, 0);
        end else begin
          check($sformatf("data[%0d]", sb[0].idx), $signed(bus.out_data), sb[0].data);
          check("idx", bus.out_idx, sb[0].idx);
          check($sformatf("last[%0d]", sb[0].idx), bus.out_last, sb[0].idx == N*N-1);
          if (bus.out_ready) begin
            got[sb[0].idx] = bus.out_data;
            if (sb[0].idx == N*N-1) job_done = 1'b1;
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  task automatic send_beat(input vec_t a, input vec_t b, input bit last);
    bit ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.a_vec    = a;
    bus.b_vec    = b;
    bus.in_last  = last;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      if (ok) t_last = $time;
      #1;
    end
    if (!ok) check("in_ready_timeout", bus.in_ready, 1);
  endtask

  task automatic drain_main(input bit stall);
    int hold = 0;
    bit seen3 = 1'b0;
    bit tog = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 300 && !job_done; c++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) check("in_ready_during_out", bus.in_ready, 0);
      if (stall && !seen3 && bus.out_valid && bus.out_idx == 3) begin
        seen3 = 1'b1;
        hold  = 5;
      end
      if (hold > 0) begin
        bus.out_ready = 1'b0;
        hold--;
      end else if (seen3) begin
        bus.out_ready = tog;
        tog = !tog;
      end else begin
        bus.out_ready = 1'b1;
      end
    end
    bus.out_ready = 1'b1;
    check("job_done", job_done, 1);
  endtask

  task automatic run_job(input job_t j);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        sb.push_back('{idx: r*N + c, data: model(j, r, c)});
    first_seen = 1'b0;
    job_done   = 1'b0;
    for (int k = 0; k < j.k; k++) begin
      send_beat(j.a[k], j.b[k], k == j.k - 1);
      if (j.bubbles && k < j.k - 1) begin
        // Bubble with junk operands and in_last high: must be ignored entirely.
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b1;
        bus.a_vec    = lanes(7, 7, 7, 7);
        bus.b_vec    = lanes(7, 7, 7, 7);
        @(posedge clk);
        #1;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    drain_main(j.stall);
    check({j.name, "_latency"}, int'((t_first - t_last - P/2) / P), 2*N);
    check({j.name, "_in_ready_after"}, bus.in_ready, 1);
    check({j.name, "_idle_after"}, bus.busy, 0);
    check({j.name, "_sb_empty"}, sb.size(), 0);
    check({j.name, "_err_len"}, bus.err_len, 0);
    for (int s = 0; s < 2; s++)
      check($sformatf("%s_spot%0d", j.name, j.spot_idx[s]), got[j.spot_idx[s]], j.spot_val[s]);
  endtask

  task automatic read8(input longint exp, input string tag);
    int n = 0;
    for (int c = 0; c < 100 && n < N*N; c++) begin
      @(negedge clk);
      if (bus8.out_valid && bus8.out_ready) begin
        check($sformatf("%s_data[%0d]", tag, n), $signed(bus8.out_data), exp);
        check($sformatf("%s_idx", tag), bus8.out_idx, n);
        check($sformatf("%s_last[%0d]", tag, n), bus8.out_last, n == N*N-1);
        n++;
      end
    end
    check({tag, "_words"}, n, N*N);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_acc;
    bus.in_valid  = 1'b0; bus.in_last  = 1'b0; bus.a_vec  = '0; bus.b_vec  = '0; bus.out_ready  = 1'b1;
    bus8.in_valid = 1'b0; bus8.in_last = 1'b0; bus8.a_vec = '0; bus8.b_vec = '0; bus8.out_ready = 1'b1;
    job_done = 1'b0; first_seen = 1'b0; t_first = 0; t_last = 0;

    jobs[0].name = "k1"; jobs[0].k = 1; jobs[0].bubbles = 0; jobs[0].stall = 0;
    jobs[0].a[0] = lanes(1, 2, 3, 4); jobs[0].b[0] = lanes(5, 6, 7, 8);
    jobs[0].spot_idx = '{6, 15}; jobs[0].spot_val = '{14, 32};

    jobs[1].name = "ident"; jobs[1].k = 4; jobs[1].bubbles = 1; jobs[1].stall = 1;
    for (int k = 0; k < 4; k++) begin
      jobs[1].a[k] = lanes(int'(k == 0), int'(k == 1), int'(k == 2), int'(k == 3));
      jobs[1].b[k] = lanes(10*k, 10*k + 1, 10*k + 2, 10*k + 3);
    end
    jobs[1].spot_idx = '{7, 15}; jobs[1].spot_val = '{13, 33};

    jobs[2].name = "minmin"; jobs[2].k = 2; jobs[2].bubbles = 0; jobs[2].stall = 0;
    for (int k = 0; k < 2; k++) begin
      jobs[2].a[k] = lanes(-32768, -32768, -32768, -32768);
      jobs[2].b[k] = lanes(-32768, -32768, -32768, -32768);
    end
    jobs[2].spot_idx = '{0, 9}; jobs[2].spot_val = '{64'sd2147483648, 64'sd2147483648};

    jobs[3].name = "maxneg"; jobs[3].k = 2; jobs[3].bubbles = 0; jobs[3].stall = 0;
    for (int k = 0; k < 2; k++) begin
      jobs[3].a[k] = lanes(32767, 32767, 32767, 32767);
      jobs[3].b[k] = lanes(-1, -1, -1, -1);
    end
    jobs[3].spot_idx = '{5, 15}; jobs[3].spot_val = '{-65534, -65534};

    rj.name = "after_rst"; rj.k = 1; rj.bubbles = 0; rj.stall = 0;
    rj.a[0] = lanes(1, 1, 1, 1); rj.b[0] = lanes(1, 1, 1, 1);
    rj.spot_idx = '{0, 15}; rj.spot_val = '{1, 1};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_idx", bus.out_idx, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_err_len", bus.err_len, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    for (int t = 0; t < 4; t++) run_job(jobs[t]);

    // Reset pulsed mid-drain: the aborted job must produce nothing.
    send_beat(lanes(2, 2, 2, 2), lanes(2, 2, 2, 2), 1'b1);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    @(posedge clk); #1;
    check("drain_in_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("post_rst_busy", bus.busy, 0);
    check("post_rst_out_valid", bus.out_valid, 0);
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      check("post_rst_quiet", bus.out_valid, 0);
    end
    run_job(rj);

    // KMAX=8 instance: 10 beats offered without in_last, only 8 accepted.
    n_acc = 0;
    bus8.in_valid = 1'b1;
    bus8.in_last  = 1'b0;
    bus8.a_vec    = lanes(1, 1, 1, 1);
    bus8.b_vec    = lanes(1, 1, 1, 1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus8.in_ready) n_acc++;
      @(posedge clk); #1;
    end
    bus8.in_valid = 1'b0;
    check("k8_accepted", n_acc, 8);
    check("k8_err_len_set", bus8.err_len, 1);
    read8(8, "k8");
    check("k8_err_len_held", bus8.err_len, 1);
    bus8.in_valid = 1'b1;
    bus8.in_last  = 1'b1;
    @(negedge clk);
    check("k8_next_in_ready", bus8.in_ready, 1);
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    bus8.in_last  = 1'b0;
    check("k8_err_len_clear", bus8.err_len, 0);
    read8(1, "k8_next");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_mm_engine.md
Name: systolic_mm_engine

Overview:
- Parametrised output-stationary NxN systolic matrix-multiply engine computing C = A x B, where A is NxK and B is KxN.
- Successor to the fixed 3x3 MAC array. Adds:
  - generic N and widths;
  - internal input skewing;
  - a valid/ready job interface with a variable inner dimension K;
  - a drain phase;
  - serialised, back-pressured result readout.
- Sits between the operand fetch stream and the result writeback stream.

Parameters:
- N, 4, array dimension (rows = cols = N), 2..8.
- DATA_W, 16, signed operand width.
- ACC_W, 40, signed accumulator/result width; must be >= 2*DATA_W.
- KMAX, 256, maximum beats per job (inner dimension K).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  engine accepts a beat.
- in_last  in  1  marks the final beat (k = K-1) of a job.
- a_vec  in  N*DATA_W  lane i = A[i][k] (lane 0 in LSBs).
- b_vec  in  N*DATA_W  lane j = B[k][j].
- out_valid  out  1  result word valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  ACC_W  C[r][c], two's complement.
- out_idx  out  clog2(N*N)  r*N + c, row-major.
- out_last  out  1  high with idx N*N-1.
- busy  out  1  state != IDLE.
- err_len  out  1  sticky flag: the job was truncated at KMAX beats.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - All accumulators, skew registers and PE pipeline registers are zeroed.
  - Outputs: in_ready=0 during rst, out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, err_len=0.
  - Reset asserted mid-job aborts the job; no partial results are emitted.
- Handshake: transfer occurs on an edge where valid & ready are both high. While out_valid=1 and out_ready=0, out_data, out_idx and out_last hold stable.
- FSM states: IDLE -> LOAD -> DRAIN -> OUT -> IDLE.
  - IDLE:
    - in_ready=1.
    - An accepted beat clears all N*N accumulators in the same cycle, is fed to the array as k=0, and moves to LOAD (or DRAIN if in_last).
    - err_len clears on this first beat.
  - LOAD:
    - in_ready=1.
    - Each accepted beat feeds the array. Cycles with in_valid=0 inject zero operands (bubbles are allowed; results are unaffected).
    - An accepted beat with in_last=1 moves to DRAIN.
    - Beat counter: when the KMAX-th beat is accepted without in_last, treat it as last, set err_len, and move to DRAIN.
  - DRAIN:
    - in_ready=0. Zero operands are injected.
    - Lasts 2N-1 cycles, counted from the edge after the last-beat handshake.
  - OUT:
    - out_valid=1 with idx 0.
    - Each out transfer increments idx. The transfer at idx N*N-1 returns to IDLE; in_ready=1 on the following cycle.
- Array timing:
  - Row i of A is delayed by i registers before PE(i,0); column j of B is delayed by j registers before PE(0,j).
  - Each PE registers a to its right neighbour and b to its lower neighbour.
  - PE(i,j) sees beat k at cycle k+i+j after that beat's acceptance.
- Latency: first out_valid is asserted exactly 2N cycles after the edge that accepted the last beat.
- Arithmetic:
  - Full signed DATA_W x DATA_W product, sign-extended to ACC_W.
  - Accumulate modulo 2^ACC_W: wrap, no saturation, no flag.
- Minimum job is K=1 (a single beat with in_last=1 accepted in IDLE).
- in_last is ignored when in_valid=0.

Test Plan:
- K=1, N=4, a_vec lanes = 1,2,3,4, b_vec lanes = 5,6,7,8, in_last=1 -> 16 words. Expected: C[1][2]=14 (idx 6), C[3][3]=32 (idx 15), out_last only on idx 15. First out_valid 8 cycles after acceptance.
- K=4 with A = identity, B[k][j] = 10k+j, in_valid toggled 1-0-1-0 (bubbles) -> C = B exactly, e.g. idx 7 = 13. Confirms bubbles do not corrupt results.
- Signed K=2: all lanes a = -32768, b = -32768 -> every C = 2^31 = 2147483648. Then a = 32767, b = -1 over K=2 -> every C = -65534.
- out_ready held low for 5 cycles at idx 3, then pulsed every other cycle -> idx 3 data stable while stalled, no word lost or duplicated. in_ready stays 0 until the cycle after the idx 15 transfer.
- KMAX=8 build, 10 beats of all 1s with no in_last -> err_len=1, and every C = 8. Beats 9-10 are not accepted (in_ready=0). err_len clears on the next job's first beat.
- rst pulsed for 1 cycle during DRAIN, then a K=1 job (all lanes 1,1) -> no stale output; out_valid=0 after reset, and all new results = 1.
